// File: rtl/gso_deflate_seq_if.sv
// -----------------------------------------------------------------------------
// gso_deflate_seq_if
// Handshake bundle between the Gram-Schmidt deflation sequencer and the shared
// CORDIC rotator.
//   en        : one-cycle rotation request (sequencer -> rotator)
//   xin, yin  : rotation operands
//   angle     : rotation angle phi, +2^(ANGLE_WIDTH-1) represents +pi
//   xout,yout : gain-corrected rotation result (rotator -> sequencer)
//   opvld     : result valid strobe
// Modports: master = sequencer side, slave = rotator side.
// -----------------------------------------------------------------------------
interface gso_deflate_seq_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16
);
  logic                          en;
  logic signed [DATA_WIDTH-1:0]  xin;
  logic signed [DATA_WIDTH-1:0]  yin;
  logic signed [ANGLE_WIDTH-1:0] angle;
  logic signed [DATA_WIDTH-1:0]  xout;
  logic signed [DATA_WIDTH-1:0]  yout;
  logic                          opvld;

  modport master (output en, xin, yin, angle, input xout, yout, opvld);
  modport slave  (input en, xin, yin, angle, output xout, yout, opvld);
endinterface

// File: rtl/gso_deflate_seq.sv
// -----------------------------------------------------------------------------
// gso_deflate_seq
// Deflates weight vector w against k previously found unit vectors (each given
// as N_DIM-1 hyperspherical angles), one vector at a time, using an external
// CORDIC rotator: w := w - sum_j (w.u_j) u_j.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, abort    : begin operation (IDLE only) / synchronous cancel
//   k_in            : vector count, clamped to MAX_VEC
//   w_in_flat       : input w, element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   thetas_in_flat  : theta[j][i] at angle index j*(N_DIM-1)+i
//   rot             : CORDIC handshake (master side)
//   w_out_flat      : deflated w, same packing as w_in_flat
//   s_out_flat      : per-vector dot products s_j
//   busy, done      : not-IDLE flag / one-cycle completion pulse
//   err_timeout     : sticky rotator timeout, cleared by the next start
// -----------------------------------------------------------------------------
module gso_deflate_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int N_DIM       = 7,
  parameter int MAX_VEC     = 6,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic [3:0]                                k_in,
  input  logic [DATA_WIDTH*N_DIM-1:0]               w_in_flat,
  input  logic [ANGLE_WIDTH*MAX_VEC*(N_DIM-1)-1:0]  thetas_in_flat,
  gso_deflate_seq_if.master                         rot,
  output logic [DATA_WIDTH*N_DIM-1:0]               w_out_flat,
  output logic [DATA_WIDTH*MAX_VEC-1:0]             s_out_flat,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err_timeout
);
  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ANGLE_WIDTH;
  localparam int NA  = N_DIM - 1;
  localparam int NTH = MAX_VEC * NA;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic signed [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [AW-1:0] A_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] A_MIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CHECK, S_DOT_ISSUE, S_DOT_WAIT,
    S_REC_ISSUE, S_REC_WAIT, S_SUB, S_NEXT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             j_q, k_q, cnt_q;
  logic [TW-1:0]          tmr_q;
  logic signed [DW-1:0]   acc_q, s_cur_q, xin_q, yin_q;
  logic signed [AW-1:0]   ang_q;
  logic                   en_q, err_q;
  logic signed [DW-1:0]   w_q   [N_DIM];
  logic signed [DW-1:0]   p_q   [N_DIM];
  logic signed [DW-1:0]   w_sub [N_DIM];
  logic signed [DW-1:0]   s_q   [MAX_VEC];
  logic signed [AW-1:0]   th_q  [NTH];

  logic                   kill, is_dot, last_rot, tmr_hit;
  int                     rot_i, th_idx;
  logic signed [DW-1:0]   w_sel;
  logic signed [AW-1:0]   th_sel, th_neg;

  assign kill     = abort && (state_q != S_IDLE);
  assign is_dot   = (state_q == S_DOT_ISSUE) || (state_q == S_DOT_WAIT);
  assign last_rot = (cnt_q == 4'(N_DIM - 2));
  assign tmr_hit  = (tmr_q == TW'(TIMEOUT_CYC - 1));

  // Dot pass walks the angles from the top index down, reconstruction walks up.
  always_comb begin
    rot_i  = is_dot ? (N_DIM - 2) - int'(cnt_q) : int'(cnt_q);
    th_idx = int'(j_q) * NA + rot_i;
    w_sel  = '0;
    th_sel = '0;
    for (int n = 0; n < N_DIM; n++) if (n == rot_i)  w_sel  = w_q[n];
    for (int n = 0; n < NTH; n++)   if (n == th_idx) th_sel = th_q[n];
    // -(-pi) is not representable; saturate to the largest positive angle.
    th_neg = (th_sel == A_MIN) ? A_MAX : -th_sel;
  end

  // Saturating subtract and output packing per element.
  for (genvar gi = 0; gi < N_DIM; gi++) begin : g_elem
    logic signed [DW:0] diff;
    assign diff = {w_q[gi][DW-1], w_q[gi]} - {p_q[gi][DW-1], p_q[gi]};
    assign w_sub[gi] = (diff[DW] != diff[DW-1]) ? (diff[DW] ? D_MIN : D_MAX)
                                                : diff[DW-1:0];
    assign w_out_flat[(gi+1)*DW-1 -: DW] = w_q[gi];
  end

  for (genvar gi = 0; gi < MAX_VEC; gi++) begin : g_s
    assign s_out_flat[(gi+1)*DW-1 -: DW] = s_q[gi];
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:      if (start) state_d = S_LOAD;
        S_LOAD:      state_d = S_CHECK;
        S_CHECK:     state_d = (j_q >= k_q) ? S_DONE : S_DOT_ISSUE;
        S_DOT_ISSUE: state_d = S_DOT_WAIT;
        S_DOT_WAIT:
          if (rot.opvld) state_d = last_rot ? S_REC_ISSUE : S_DOT_ISSUE;
          else if (tmr_hit) state_d = S_DONE;
        S_REC_ISSUE: state_d = S_REC_WAIT;
        S_REC_WAIT:
          if (rot.opvld) state_d = last_rot ? S_SUB : S_REC_ISSUE;
          else if (tmr_hit) state_d = S_DONE;
        S_SUB:       state_d = S_NEXT;
        S_NEXT:      state_d = S_CHECK;
        S_DONE:      state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q <= '0; k_q <= '0; cnt_q <= '0; tmr_q <= '0;
      acc_q <= '0; s_cur_q <= '0; xin_q <= '0; yin_q <= '0; ang_q <= '0;
      en_q <= 1'b0; err_q <= 1'b0;
      for (int n = 0; n < N_DIM; n++) begin w_q[n] <= '0; p_q[n] <= '0; end
      for (int n = 0; n < MAX_VEC; n++) s_q[n] <= '0;
      for (int n = 0; n < NTH; n++) th_q[n] <= '0;
    end else begin
      en_q <= 1'b0;  // request lasts exactly the first WAIT cycle
      if (!kill) begin
        unique case (state_q)
          S_LOAD: begin
            for (int n = 0; n < N_DIM; n++) w_q[n] <= w_in_flat[n*DW +: DW];
            for (int n = 0; n < NTH; n++) th_q[n] <= thetas_in_flat[n*AW +: AW];
            for (int n = 0; n < MAX_VEC; n++) s_q[n] <= '0;
            k_q   <= (k_in > 4'(MAX_VEC)) ? 4'(MAX_VEC) : k_in;
            j_q   <= '0;
            err_q <= 1'b0;
          end
          S_CHECK: begin
            cnt_q <= '0;
            acc_q <= w_q[N_DIM-1];
          end
          S_DOT_ISSUE, S_REC_ISSUE: begin
            xin_q <= is_dot ? w_sel : acc_q;
            yin_q <= is_dot ? acc_q : '0;
            ang_q <= is_dot ? th_neg : th_sel;
            en_q  <= 1'b1;
            tmr_q <= '0;
          end
          S_DOT_WAIT, S_REC_WAIT: begin
            if (rot.opvld) begin
              if (is_dot) begin
                acc_q <= rot.xout;
                if (last_rot) s_cur_q <= rot.xout;
              end else begin
                acc_q <= rot.yout;
                for (int n = 0; n < N_DIM; n++)
                  if (n == int'(cnt_q)) p_q[n] <= rot.xout;
                if (last_rot) p_q[N_DIM-1] <= rot.yout;
              end
              cnt_q <= last_rot ? 4'd0 : cnt_q + 4'd1;
            end else begin
              tmr_q <= tmr_q + 1'b1;
              if (tmr_hit) err_q <= 1'b1;
            end
          end
          S_SUB: for (int n = 0; n < N_DIM; n++) w_q[n] <= w_sub[n];
          S_NEXT: begin
            for (int n = 0; n < MAX_VEC; n++)
              if (n == int'(j_q)) s_q[n] <= s_cur_q;
            j_q <= j_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err_timeout = err_q;
  assign rot.en      = en_q;
  assign rot.xin     = xin_q;
  assign rot.yin     = yin_q;
  assign rot.angle   = ang_q;
endmodule

// File: tb/tb_gso_deflate_seq.sv
// -----------------------------------------------------------------------------
// tb_gso_deflate_seq
// Directed bench for gso_deflate_seq with N_DIM=4, MAX_VEC=6. A behavioural
// rotator answers each request 3 cycles after en (ideal math, a saturating
// stub, or silence for the timeout case).
// -----------------------------------------------------------------------------
module tb_gso_deflate_seq;
  localparam int DW = 16, AW = 16, N = 4, MV = 6, NA = N - 1;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] k_in = '0;
  logic [DW*N-1:0] w_in_flat = '0;
  logic [AW*MV*NA-1:0] thetas_in_flat = '0;
  logic [DW*N-1:0] w_out_flat;
  logic [DW*MV-1:0] s_out_flat;
  logic busy, done, err_timeout;

  gso_deflate_seq_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) rif ();

  gso_deflate_seq #(
    .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_DIM(N), .MAX_VEC(MV), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_in(k_in),
    .w_in_flat(w_in_flat), .thetas_in_flat(thetas_in_flat), .rot(rif),
    .w_out_flat(w_out_flat), .s_out_flat(s_out_flat),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // ---------------- rotator model: mode 0 ideal, 1 stub, 2 silent ----------
  int rot_mode = 0;
  logic [2:0] pv = '0;
  logic signed [DW-1:0] px [3] = '{default: '0};
  logic signed [DW-1:0] py [3] = '{default: '0};

  function automatic logic signed [DW-1:0] to_fix(input real r);
    real q;
    q = (r >= 0.0) ? r + 0.5 : r - 0.5;
    if (q > 32767.0) return 16'sh7fff;
    if (q < -32768.0) return 16'sh8000;
    return 16'($rtoi(q));
  endfunction

  function automatic logic signed [DW-1:0] rot_res(input logic signed [DW-1:0] x,
      input logic signed [DW-1:0] y, input logic signed [AW-1:0] a, input bit want_y);
    real ph;
    ph = real'(a) * PI / 32768.0;
    if (want_y) return to_fix(real'(x) * $sin(ph) + real'(y) * $cos(ph));
    return to_fix(real'(x) * $cos(ph) - real'(y) * $sin(ph));
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[1:0], rif.en};
    px[0] <= (rot_mode == 1) ? 16'sh8000 : rot_res(rif.xin, rif.yin, rif.angle, 1'b0);
    py[0] <= (rot_mode == 1) ? 16'sh0000 : rot_res(rif.xin, rif.yin, rif.angle, 1'b1);
    px[1] <= px[0]; px[2] <= px[1];
    py[1] <= py[0]; py[2] <= py[1];
  end

  assign rif.opvld = pv[2] && (rot_mode != 2);
  assign rif.xout  = px[2];
  assign rif.yout  = py[2];

  // ---------------- monitor ----------------
  int en_cnt = 0, done_cnt = 0;
  logic signed [AW-1:0] ang_log [256];
  always @(posedge clk) begin
    if (rif.en) begin
      ang_log[8'(en_cnt)] <= rif.angle;
      en_cnt <= en_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_bad = 0;
  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wo(input int i);
    return longint'($signed(w_out_flat[i*DW +: DW]));
  endfunction
  function automatic longint so(input int i);
    return longint'($signed(s_out_flat[i*DW +: DW]));
  endfunction

  task automatic set_w(input int a, input int b, input int c, input int d);
    w_in_flat = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask
  task automatic set_th(input int j, input int i, input int v);
    thetas_in_flat[(j*NA+i)*AW +: AW] = 16'(v);
  endtask

  // Start in the current cycle (cycle 0), return the cycle in which done is seen.
  task automatic run_op(input string name, input int restart_at, output int cyc);
    int c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (!done && c < 3000) begin
      start = (c == restart_at);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    cyc = c;
    $display("op %s: k_in=%0d done at cycle %0d", name, k_in, c);
    @(negedge clk);
  endtask

  int cyc, e0, d0, c;
  int exp_ang [6] = '{0, 0, -16384, 16384, 0, 0};

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_en", rif.en, 0);
    check_val("rst_err", err_timeout, 0);
    check_val("rst_w0", wo(0), 0);
    check_val("rst_s0", so(0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero angles, k=1
    set_w(1000, 200, 300, 400); k_in = 4'd1;
    e0 = en_cnt; d0 = done_cnt;
    run_op("zero_theta", -1, cyc);
    check_val("t1_cycles", cyc, 36);
    check_val("t1_s0", so(0), 1000);
    check_val("t1_w0", wo(0), 0);
    check_val("t1_w1", wo(1), 200);
    check_val("t1_w2", wo(2), 300);
    check_val("t1_w3", wo(3), 400);
    check_val("t1_en_pulses", en_cnt - e0, 6);
    check_val("t1_done_pulses", done_cnt - d0, 1);

    // start pulsed while busy is ignored
    e0 = en_cnt; d0 = done_cnt;
    run_op("restart_ignored", 10, cyc);
    check_val("rs_cycles", cyc, 36);
    check_val("rs_s0", so(0), 1000);
    check_val("rs_en_pulses", en_cnt - e0, 6);
    check_val("rs_done_pulses", done_cnt - d0, 1);

    // theta[0] = (pi/2, 0, 0)
    set_th(0, 0, 16384);
    e0 = en_cnt;
    run_op("theta_pi2", -1, cyc);
    check_val("t2_cycles", cyc, 36);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("t2_angle%0d", i), ang_log[e0+i], exp_ang[i]);
    check_val("t2_s0", so(0), 200);
    check_val("t2_w0", wo(0), 1000);
    check_val("t2_w1", wo(1), 0);
    check_val("t2_w2", wo(2), 300);
    check_val("t2_w3", wo(3), 400);

    // k=2, zero angles
    set_th(0, 0, 0); k_in = 4'd2;
    run_op("k2", -1, cyc);
    check_val("t3_cycles", cyc, 69);
    check_val("t3_s0", so(0), 1000);
    check_val("t3_s1", so(1), 0);
    check_val("t3_w0", wo(0), 0);
    check_val("t3_w3", wo(3), 400);

    // k_in above MAX_VEC clamps to six passes
    k_in = 4'd9;
    e0 = en_cnt; d0 = done_cnt;
    run_op("k9_clamp", -1, cyc);
    check_val("t3b_cycles", cyc, 201);
    check_val("t3b_en_pulses", en_cnt - e0, 36);
    check_val("t3b_done_pulses", done_cnt - d0, 1);
    check_val("t3b_s0", so(0), 1000);

    // saturating stub rotator, theta[0][0] = -pi
    rot_mode = 1; k_in = 4'd1;
    set_th(0, 0, -32768);
    set_w(32000, 0, 0, 0);
    e0 = en_cnt;
    run_op("stub_sat", -1, cyc);
    check_val("t4_cycles", cyc, 36);
    check_val("t4_s0", so(0), -32768);
    check_val("t4_w0", wo(0), 32767);
    check_val("t4_w1", wo(1), 32767);
    check_val("t4_w3", wo(3), 0);
    check_val("t4_dot_angle_neg_sat", ang_log[e0+2], 32767);
    check_val("t4_rec_angle", ang_log[e0+3], -32768);

    // silent rotator -> timeout
    rot_mode = 2; set_th(0, 0, 0);
    set_w(1000, 200, 300, 400);
    e0 = en_cnt; d0 = done_cnt;
    run_op("timeout", -1, cyc);
    check_val("t5_cycles", cyc, 68);
    check_val("t5_err", err_timeout, 1);
    check_val("t5_w0", wo(0), 1000);
    check_val("t5_en_pulses", en_cnt - e0, 1);
    check_val("t5_done_pulses", done_cnt - d0, 1);

    // k=0, also clears the sticky error
    rot_mode = 0; k_in = 4'd0;
    set_w(11, -22, 33, -44);
    e0 = en_cnt;
    run_op("k0", -1, cyc);
    check_val("t6_cycles", cyc, 3);
    check_val("t6_err_cleared", err_timeout, 0);
    check_val("t6_w0", wo(0), 11);
    check_val("t6_w1", wo(1), -22);
    check_val("t6_w3", wo(3), -44);
    check_val("t6_en_pulses", en_cnt - e0, 0);

    // abort in the first reconstruction wait
    set_w(1000, 200, 300, 400); k_in = 4'd1;
    e0 = en_cnt; d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while ((en_cnt - e0) < 4 && c < 200) begin
      @(negedge clk);
      c++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("ab_busy_next", busy, 0);
    repeat (10) @(negedge clk);
    $display("op abort: aborted at cycle %0d", c);
    check_val("ab_busy_later", busy, 0);
    check_val("ab_done_pulses", done_cnt - d0, 0);
    check_val("ab_en_pulses", en_cnt - e0, 4);
    check_val("ab_w0", wo(0), 1000);
    check_val("ab_w1", wo(1), 200);
    check_val("ab_s0", so(0), 0);

    // abort in IDLE is ignored, then a normal run recovers
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("idle_abort_busy", busy, 0);
    run_op("recover", -1, cyc);
    check_val("rc_cycles", cyc, 36);
    check_val("rc_s0", so(0), 1000);
    check_val("rc_w0", wo(0), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
